// File: rtl/alu_muldiv_if.sv
// Operand/result bundle for alu_muldiv: EX-stage operands, ctrl/start handshake,
// combinational result flags and the HI/LO multiply/divide results.
interface alu_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [3:0]       ctrl;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_1, in_2, ctrl, start,
    input  result, zero, overflow, busy, done, hi, lo
  );

  modport slave (
    input  in_1, in_2, ctrl, start,
    output result, zero, overflow, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS EX-stage ALU: single-cycle logic/arith/compare ops plus an iterative
// unsigned MULTU/DIVU unit (one bit per cycle) writing HI/LO on completion.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd, work_hi, work_lo;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic             busy;
  logic             accept_mul, accept_div, last;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [WIDTH-1:0] sum, diff, result;
  logic             overflow;

  assign accept_mul = (state == IDLE) && bus.start && (bus.ctrl == 4'b1000);
  assign accept_div = (state == IDLE) && bus.start && (bus.ctrl == 4'b1001);
  assign last       = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept_mul)      state_nxt = MUL;
        else if (accept_div) state_nxt = DIV;
      end
      MUL, DIV: if (last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // work_hi:work_lo is the product accumulator (MUL) or remainder:quotient (DIV);
  // opnd holds the latched multiplicand or divisor.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (state == MUL) begin
      {nxt_hi, nxt_lo} = {mul_sum, work_lo[WIDTH-1:1]};
    end else begin
      nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      nxt_lo = {work_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      opnd    <= '0;
      work_hi <= '0;
      work_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_mul) begin
        opnd    <= bus.in_1;
        work_hi <= '0;
        work_lo <= bus.in_2;
        cnt     <= CW'(WIDTH);
      end else if (accept_div) begin
        opnd    <= bus.in_2;
        work_hi <= '0;
        work_lo <= bus.in_1;
        cnt     <= CW'(WIDTH);
      end else if (busy) begin
        work_hi <= nxt_hi;
        work_lo <= nxt_lo;
        cnt     <= cnt - CW'(1);
        if (last) begin
          hi_q   <= nxt_hi;
          lo_q   <= nxt_lo;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign sum  = bus.in_1 + bus.in_2;
  assign diff = bus.in_1 - bus.in_2;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    unique case (bus.ctrl)
      4'b0000: result = bus.in_1 & bus.in_2;
      4'b0001: result = bus.in_1 | bus.in_2;
      4'b0010: begin
        result   = sum;
        overflow = (bus.in_1[WIDTH-1] == bus.in_2[WIDTH-1]) && (sum[WIDTH-1] != bus.in_1[WIDTH-1]);
      end
      4'b0110: begin
        result   = diff;
        overflow = (bus.in_1[WIDTH-1] != bus.in_2[WIDTH-1]) && (diff[WIDTH-1] != bus.in_1[WIDTH-1]);
      end
      4'b0111: result = {{(WIDTH-1){1'b0}}, $signed(bus.in_1) < $signed(bus.in_2)};
      4'b0101: result = {{(WIDTH-1){1'b0}}, bus.in_1 < bus.in_2};
      4'b1100: result = ~(bus.in_1 | bus.in_2);
      4'b1110: result = hi_q;
      4'b1111: result = lo_q;
      default: result = '0;
    endcase
  end

  assign bus.result   = result;
  assign bus.zero     = (result == '0);
  assign bus.overflow = overflow;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: 32-bit and 8-bit instances, directed corners
// plus randomized ALU and MULTU/DIVU traffic against a plain-arithmetic model.
module tb_alu_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(32)) b32 ();
  alu_muldiv_if #(.WIDTH(8))  b8 ();

  alu_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  alu_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [63:0] sb32[$];
  logic [15:0] sb8[$];
  logic [31:0] m_hi32 = '0, m_lo32 = '0;
  logic [7:0]  m_hi8 = '0, m_lo8 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: each done pulse retires the oldest expected HI/LO pair.
  always @(negedge clk) begin
    logic [63:0] e;
    if (b32.done) begin
      chk("busy_clear_at_done32", b32.busy, 0);
      if (sb32.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done32: done pulse with empty scoreboard (t=%0t)", $time);
      end else begin
        e = sb32.pop_front();
        chk("hi32", b32.hi, e[63:32]);
        chk("lo32", b32.lo, e[31:0]);
        m_hi32 = e[63:32];
        m_lo32 = e[31:0];
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (b8.done) begin
      if (sb8.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done8: done pulse with empty scoreboard (t=%0t)", $time);
      end else begin
        e = sb8.pop_front();
        chk("hi8", b8.hi, e[15:8]);
        chk("lo8", b8.lo, e[7:0]);
        m_hi8 = e[15:8];
        m_lo8 = e[7:0];
      end
    end
  end

  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov);
    longint sa, sbv, s;
    longint maxi, mini;
    maxi = 64'sd2147483647;
    mini = -maxi - 1;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r  = '0;
    ov = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = sa + sbv; r = s[31:0]; ov = (s > maxi) || (s < mini); end
      4'b0110: begin s = sa - sbv; r = s[31:0]; ov = (s > maxi) || (s < mini); end
      4'b0111: r = (sa < sbv) ? 32'd1 : 32'd0;
      4'b0101: r = (a < b) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b1110: r = m_hi32;
      4'b1111: r = m_lo32;
      default: r = '0;
    endcase
  endfunction

  task automatic comb32(input string name, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic ov;
    @(negedge clk);
    b32.ctrl = c; b32.in_1 = a; b32.in_2 = b; b32.start = 1'b0;
    #2;
    ref_alu(c, a, b, r, ov);
    chk({name, "_result"}, b32.result, r);
    chk({name, "_zero"}, b32.zero, (r == 0));
    chk({name, "_ovf"}, b32.overflow, ov);
  endtask

  function automatic logic [63:0] ref_md32(input logic mul, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (mul) begin
      p = {32'b0, a} * {32'b0, b};
      return p;
    end
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  int c0_32;

  task automatic launch32(input logic mul, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    b32.ctrl = mul ? 4'b1000 : 4'b1001; b32.in_1 = a; b32.in_2 = b; b32.start = 1'b1;
    @(posedge clk);
    c0_32 = cyc + 1;
    sb32.push_back(ref_md32(mul, a, b));
    #1;
    b32.start = 1'b0;
    b32.ctrl  = 4'b0000;
  endtask

  task automatic wait_done32(input string name);
    while (!b32.done && (cyc - c0_32) < 40) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_latency"}, cyc - c0_32, 32);
  endtask

  task automatic op8(input string name, input logic mul, input logic [7:0] a, input logic [7:0] b);
    int c0;
    logic [15:0] e;
    e = mul ? ({8'b0, a} * {8'b0, b}) : ((b == 0) ? {a, 8'hFF} : {a % b, a / b});
    @(negedge clk);
    b8.ctrl = mul ? 4'b1000 : 4'b1001; b8.in_1 = a; b8.in_2 = b; b8.start = 1'b1;
    @(posedge clk);
    c0 = cyc + 1;
    sb8.push_back(e);
    #1;
    b8.start = 1'b0;
    b8.ctrl  = 4'b0000;
    while (!b8.done && (cyc - c0) < 20) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_latency8"}, cyc - c0, 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes[10];
    logic [31:0] a, b;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b1100, 4'b1110, 4'b1111, 4'b1011};
    b32.in_1 = '0; b32.in_2 = '0; b32.ctrl = 4'b1110; b32.start = 1'b0;
    b8.in_1  = '0; b8.in_2  = '0; b8.ctrl  = 4'b0000; b8.start  = 1'b0;

    #2;
    chk("rst_busy", b32.busy, 0);
    chk("rst_done", b32.done, 0);
    chk("rst_hi", b32.hi, 0);
    chk("rst_lo", b32.lo, 0);
    chk("rst_busy8", b8.busy, 0);
    comb32("rst_mfhi", 4'b1110, 32'h1234, 32'h5678);
    @(negedge clk);
    rst_n = 1'b1;

    comb32("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1);
    comb32("sub_zero", 4'b0110, 32'd5, 32'd5);
    comb32("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1);
    comb32("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1);
    comb32("sltu", 4'b0101, 32'hFFFF_FFFF, 32'h1);
    comb32("nor", 4'b1100, 32'h0, 32'h0);
    comb32("undef", 4'b1011, 32'hDEAD_BEEF, 32'h1);
    comb32("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    comb32("or", 4'b0001, 32'hF000_0000, 32'h0000_000F);

    // start with a non-muldiv ctrl must leave the unit idle
    @(negedge clk);
    b32.ctrl = 4'b0010; b32.start = 1'b1;
    @(posedge clk);
    #1;
    chk("start_other_ctrl_busy", b32.busy, 0);
    b32.start = 1'b0;

    launch32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("busy_after_start", b32.busy, 1);
    wait_done32("multu_max");
    comb32("mfhi_multu", 4'b1110, 32'h0, 32'h0);
    comb32("mflo_multu", 4'b1111, 32'h0, 32'h0);

    launch32(1'b0, 32'd100, 32'd7);
    wait_done32("divu_100_7");
    launch32(1'b0, 32'd100, 32'd0);
    wait_done32("divu_by_zero");
    comb32("mfhi_div0", 4'b1110, 32'h0, 32'h0);

    // restart attempt, operand change and combinational use while busy
    launch32(1'b1, 32'h0001_2345, 32'h0000_ABCD);
    repeat (3) @(posedge clk);
    @(negedge clk);
    b32.in_1 = 32'd100; b32.in_2 = 32'd7; b32.ctrl = 4'b1001; b32.start = 1'b1;
    @(posedge clk);
    #1;
    b32.start = 1'b0;
    comb32("add_during_busy", 4'b0010, 32'd100, 32'd7);
    comb32("mfhi_during_busy", 4'b1110, 32'd100, 32'd7);
    wait_done32("multu_ignored_start");

    // reset mid-DIVU: abort, clear HI/LO, no done
    launch32(1'b0, 32'hFFFF_0000, 32'd3);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", b32.busy, 0);
    chk("abort_done", b32.done, 0);
    chk("abort_hi", b32.hi, 0);
    chk("abort_lo", b32.lo, 0);
    sb32.delete();
    m_hi32 = '0;
    m_lo32 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    comb32("mflo_after_abort", 4'b1111, 32'h0, 32'h0);
    launch32(1'b0, 32'd1000, 32'd33);
    wait_done32("divu_after_abort");

    op8("multu8_max", 1'b1, 8'hFF, 8'hFF);
    op8("divu8", 1'b0, 8'd200, 8'd9);
    op8("divu8_zero", 1'b0, 8'd77, 8'd0);
    for (int i = 0; i < 6; i++) begin
      op8("rand8", $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom_range(0, 20)));
    end

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = a;
      if (i % 7 == 0) a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      comb32("rand_comb", codes[$urandom_range(0, 9)], a, b);
    end

    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      case (i % 3)
        0: b = $urandom;
        1: b = $urandom_range(0, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      launch32(($urandom_range(0, 1) == 1), a, b);
      wait_done32("rand_md32");
      comb32("rand_mfhi", 4'b1110, a, b);
      comb32("rand_mflo", 4'b1111, a, b);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard32_empty", sb32.size(), 0);
    chk("scoreboard8_empty", sb8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised ALU for the MIPS multicycle datapath. The single-cycle AND/OR/ADD/SUB core gains SLT, SLTU, NOR and a signed-overflow flag, plus an iterative unsigned multiply/divide unit that writes dedicated HI/LO registers. The unit sits in the EX stage. The control FSM starts a MULTU/DIVU, stalls on `busy`, and reads the results back through MFHI/MFLO ctrl codes.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 4 and even.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_1`  in  WIDTH  operand A (dividend / multiplicand)
- `in_2`  in  WIDTH  operand B (divisor / multiplier)
- `ctrl`  in  4  operation select
- `start`  in  1  launch MULTU/DIVU; sampled only when `ctrl` is 1000/1001 and `busy`=0
- `result`  out  WIDTH  combinational result
- `zero`  out  1  `result` == 0
- `overflow`  out  1  signed overflow, ADD/SUB only
- `busy`  out  1  iterative operation in progress
- `done`  out  1  one-cycle pulse, HI/LO just written
- `hi`  out  WIDTH  HI register (product upper half / remainder)
- `lo`  out  WIDTH  LO register (product lower half / quotient)

## Operation
- Combinational ctrl decode for `result`:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A−B)
  - 0111 SLT (signed, result 0 or 1)
  - 0101 SLTU (unsigned)
  - 1100 NOR
  - 1110 MFHI (`result`=`hi`)
  - 1111 MFLO (`result`=`lo`)
  - 1000/1001 and all other codes: `result`=0
- `zero` = (`result`==0) for every ctrl code, including undefined codes (zero=1).
- `overflow`:
  - ADD: operand signs equal and sum sign differs.
  - SUB: operand signs differ and difference sign differs from A.
  - All other codes: 0. Sum/difference truncated to WIDTH.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL on `start` with ctrl=1000.
  - IDLE → DIV on `start` with ctrl=1001.
  - Operands latched on that edge; counter loaded with WIDTH.
  - MUL/DIV → IDLE when counter reaches 0 after the last iteration.
- MULTU: shift-add, one multiplier bit per cycle, 2·WIDTH-bit unsigned product. {hi,lo} = A·B.
- DIVU: restoring division, one quotient bit per cycle. lo = A/B, hi = A mod B, unsigned.
- Divide by zero: no trap. Runs the full WIDTH iterations. lo = all ones, hi = A.
- `start` while `busy`=1 is ignored; latched operands are unaffected by input changes.
- `start` with any other ctrl has no sequential effect.
- Combinational ops stay fully usable while `busy`=1.
- MFHI/MFLO during `busy` return the previous HI/LO; they are written only at completion.
- Counter width is $clog2(WIDTH+1). No other internal state is visible.

## Timing
- Reset (async assert, sync release): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
  - With `rst_n` low, `result` follows ctrl decode with hi=lo=0. For example, ctrl=1110 gives `result`=0, `zero`=1.
- Start edge E0: `busy`=1 from just after E0.
- HI/LO write: at edge E_WIDTH (WIDTH edges after E0), `busy` drops to 0 and `done`=1 for exactly one cycle.
  - Latency from start edge to `done` edge is WIDTH cycles; 32 for the default.
- Back-to-back: `start` sampled at edge E_WIDTH is ignored because `busy` is still 1 in the preceding cycle. The earliest restart is the edge after `done` rises, which gives a throughput of one op per WIDTH+1 cycles.
- `rst_n` asserted mid-operation: abort immediately, HI/LO cleared, no `done` pulse.
- `done` and `busy` are never 1 simultaneously.

## Test plan
- Combinational sweep, WIDTH=32:
  - ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1.
  - SUB 5−5 → result 0, zero=1.
  - SLT 0xFFFFFFFF,1 → 1.
  - SLTU 0xFFFFFFFF,1 → 0.
  - NOR 0,0 → 0xFFFFFFFF.
  - Undefined ctrl 1011 → result 0, zero=1.
- MULTU 0xFFFFFFFF·0xFFFFFFFF → busy for 32 cycles; done pulse on the 32nd edge.
  - hi=0xFFFFFFFE, lo=0x00000001.
  - MFHI/MFLO read back the same values.
- DIVU 100/7 → lo=14, hi=2 after 32 cycles.
  - DIVU 100/0 → lo=0xFFFFFFFF, hi=100, no extra latency.
- Change in_1/in_2 and pulse `start` with ctrl=1001 during a MULTU → ignored; the product is computed from the originally latched operands.
  - ADD on new operands during busy is still correct.
- Assert `rst_n` low at cycle 10 of a DIVU → busy=0, hi=lo=0, no done.
  - A restart after release completes normally.
- WIDTH=8 instance: MULTU 0xFF·0xFF → hi=0xFE, lo=0x01 with done 8 cycles after start.
